// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: drives the PLL reset, qualifies the PLL locked signal
// on refclk and releases a downstream reset once lock has been stable.
// Bounded retries on lock timeout, then a sticky fault.
// Optional build macro: PLL_SUP_LOSS_COUNT_EN builds the loss_count register;
// when undefined loss_count is tied to zero.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int TMAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX  = (TMAX0 > STABLE_CYCLES) ? TMAX0 : STABLE_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        READY,
        FAULT
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [CNT_W-1:0] retry_n;
    logic [1:0]       sync;
    logic             locked_s;
`ifdef PLL_SUP_LOSS_COUNT_EN
    logic             loss_inc;
    logic [CNT_W-1:0] loss_q;
`endif

    assign locked_s = sync[1];

    // Two-flop synchronizer for the asynchronous PLL locked output.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], locked};
    end

    // State register, shared timer, retry counter and registered outputs.
    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PLL;
            timer       <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            retry_count <= retry_n;
            pll_rst     <= (state_n == RESET_PLL) || (state_n == FAULT);
            sys_rst     <= (state_n != READY);
            ready       <= (state_n == READY);
            fault       <= (state_n == FAULT);
        end
    end

    // Next-state logic; lock wins over timeout, a drop wins over qualification.
    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        retry_n = retry_count;
`ifdef PLL_SUP_LOSS_COUNT_EN
        loss_inc = 1'b0;
`endif
        case (state)
            RESET_PLL: begin
                if (timer == TW'(RST_CYCLES - 1)) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_n = retry_count + 1'b1;
                    state_n = (retry_n == CNT_W'(MAX_RETRIES)) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                end else if (timer == TW'(STABLE_CYCLES - 1)) begin
                    state_n = READY;
                    retry_n = '0;
                end
            end
            READY: begin
                timer_n = timer;
                if (!locked_s) begin
                    state_n = RESET_PLL;
`ifdef PLL_SUP_LOSS_COUNT_EN
                    loss_inc = 1'b1;
`endif
                end
            end
            FAULT: begin
                timer_n = timer;
            end
            default: state_n = RESET_PLL;
        endcase
        // Every state entry starts with a cleared timer.
        if (state_n != state) timer_n = '0;
    end

`ifdef PLL_SUP_LOSS_COUNT_EN
    // Saturating count of lock losses seen while READY.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)                            loss_q <= '0;
        else if (loss_inc && loss_q != '1)  loss_q <= loss_q + 1'b1;
    end
    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed test-plan scenarios plus randomized
// locked waveforms, all compared every cycle against a phase/elapsed-time model.
module tb_pll_lock_supervisor;

    localparam int RC = 4, LT = 32, SC = 8, MR = 3, W = 8;
    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RDY = 3, P_FLT = 4;

    logic         refclk = 1'b0;
    logic         rst    = 1'b1;
    logic         locked = 1'b0;
    logic         pll_rst, sys_rst, ready, fault;
    logic [W-1:0] retry_count, loss_count;

    always #10 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
        .MAX_RETRIES(MR), .CNT_W(W)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
        .retry_count(retry_count), .loss_count(loss_count)
    );

    wire [19:0] dut_v = {pll_rst, sys_rst, ready, fault, retry_count, loss_count};

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: phase plus edge count at phase entry, locked delayed 2 edges.
    int ph, cyc, t_ent, m_retry, m_loss;
    bit m_s1, m_s2;

    function automatic void m_reset();
        ph = P_RST; cyc = 0; t_ent = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
    endfunction

    function automatic void go(input int p);
        ph = p; t_ent = cyc;
    endfunction

    function automatic void m_edge(input bit lk);
        bit ls;
        int el;
        cyc++;
        ls = m_s2; m_s2 = m_s1; m_s1 = lk;
        el = cyc - t_ent;
        case (ph)
            P_RST:  if (el == RC) go(P_WAIT);
            P_WAIT: if (ls) go(P_STAB);
                    else if (el == LT) begin
                        m_retry++;
                        go(m_retry == MR ? P_FLT : P_RST);
                    end
            P_STAB: if (!ls) go(P_WAIT);
                    else if (el == SC) begin go(P_RDY); m_retry = 0; end
            P_RDY:  if (!ls) begin go(P_RST); m_loss++; end
            default: ;
        endcase
    endfunction

    function automatic logic [19:0] m_out();
        int le;
`ifdef PLL_SUP_LOSS_COUNT_EN
        le = (m_loss > 255) ? 255 : m_loss;
`else
        le = 0;
`endif
        return {(ph == P_RST || ph == P_FLT), (ph != P_RDY), (ph == P_RDY), (ph == P_FLT),
                8'(m_retry), 8'(le)};
    endfunction

    // One refclk edge with locked driven mid-cycle, then a full output compare.
    task automatic step(input bit lk);
        locked = lk;
        @(posedge refclk);
        m_edge(lk);
        #1;
        chk("outs", dut_v, m_out());
    endtask

    // Assert rst asynchronously, check reset values before any edge, release.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_vals", dut_v, 20'hC0000);
        m_reset();
        @(posedge refclk);
        #1;
        rst = 1'b0;
    endtask

    task automatic acquire();
        int k = 0;
        while (!ready && k < 100) begin step(1); k++; end
        chk("acquire", ready, 1'b1);
    endtask

    initial begin
        int k;
        int exp_loss;
        @(posedge refclk);
        #1;

        // 1: pll_rst width and lock-to-ready latency.
        do_reset();
        k = 0;
        while (pll_rst && k < 20) begin step(0); k++; end
        chk("t1_pll_rst_edges", k, RC);
        for (int i = k; i < 10; i++) step(0);
        step(1);
        k = 0;
        while (!ready && k < 50) begin step(1); k++; end
        chk("t1_ready_lat", k, SC + 2);
        chk("t1_sys_rst", sys_rst, 1'b0);
        chk("t1_retry", retry_count, 0);

        // 2: three timeouts to fault, then rst clears it.
        do_reset();
        k = 0;
        while (!fault && k < 200) begin step(0); k++; end
        chk("t2_fault_edges", k, MR * (RC + LT));
        chk("t2_retry", retry_count, MR);
        for (int i = 0; i < 20; i++) step(0);
        chk("t2_fault_hold", {fault, pll_rst}, 2'b11);
        do_reset();

        // 3: one timeout, then lock; retry clears in READY.
        for (int i = 0; i < RC + LT; i++) step(0);
        chk("t3_retry1", retry_count, 1);
        acquire();
        chk("t3_retry0", retry_count, 0);

        // 4: 3-cycle drop in READY; sys_rst rises two edges after.
        step(0); step(0);
        chk("t4_sys_rst_e1", sys_rst, 1'b0);
        step(0);
        chk("t4_sys_rst_e2", sys_rst, 1'b1);
`ifdef PLL_SUP_LOSS_COUNT_EN
        exp_loss = 1;
`else
        exp_loss = 0;
`endif
        chk("t4_loss", loss_count, exp_loss);
        acquire();

        // 5: glitch during STABLE restarts qualification without a retry.
        do_reset();
        for (int i = 0; i < RC + 2; i++) step(0);
        for (int i = 0; i < 6; i++) step(1);
        step(0);
        k = 0;
        while (!ready && k < 50) begin step(1); k++; end
        chk("t5_ready", ready, 1'b1);
        chk("t5_requal", (k >= SC), 1'b1);
        chk("t5_retry", retry_count, 0);

        // 6: 300 loss events saturate the counter.
        for (int n = 0; n < 300; n++) begin
            step(0); step(0); step(0);
            acquire();
        end
`ifdef PLL_SUP_LOSS_COUNT_EN
        exp_loss = 255;
`else
        exp_loss = 0;
`endif
        chk("t6_loss_sat", loss_count, exp_loss);

        // Randomized locked runs with occasional asynchronous reset.
        do_reset();
        for (int seg = 0; seg < 200; seg++) begin
            bit lv = 1'($urandom_range(0, 1));
            int len = lv ? $urandom_range(1, 40) : $urandom_range(1, 12);
            if ($urandom_range(0, 19) == 0) begin
                do_reset();
            end
            for (int i = 0; i < len; i++) step(lv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
